sample_timer_mc: RTL

Multi-channel programmable sample timer, the parametrised successor of the five-channel sample_timer. Each channel produces a sample clock (clk_o) and a one-cycle sample strobe. Period and time unit are set per channel. Period changes take effect only at a period boundary, so outputs never glitch. Each channel runs in continuous or one-shot mode. Sits between the register block that holds scp_period/scp_unit and the protocol capture logic that consumes the strobes.

---
 rtl/sample_timer_mc_pkg.sv | 33 +++
 rtl/sample_timer_mc_if.sv | 25 ++
 rtl/sample_timer_mc_ch.sv | 138 +++++++++++++
 rtl/sample_timer_mc.sv | 31 +++
 4 files changed

// File: rtl/sample_timer_mc_pkg.sv
// Shared definitions for the multi-channel sample timer:
// unit codes, unit multiplier, FSM encoding, counter width helper.
package sample_timer_pkg;

    localparam logic [1:0] UNIT_1US   = 2'd0;
    localparam logic [1:0] UNIT_10US  = 2'd1;
    localparam logic [1:0] UNIT_100US = 2'd2;
    localparam logic [1:0] UNIT_1MS   = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic int unit_mult(input logic [1:0] code);
        int m;
        case (code)
            UNIT_1US:   m = 1;
            UNIT_10US:  m = 10;
            UNIT_100US: m = 100;
            UNIT_1MS:   m = 1000;
            default:    m = 1;
        endcase
        return m;
    endfunction

    // Wide enough for the longest unit (1 ms) at the given clock.
    function automatic int cyc_w(input int freq_mhz);
        return (freq_mhz * 1000 > 1) ? $clog2(freq_mhz * 1000) : 1;
    endfunction

endpackage

// File: rtl/sample_timer_mc_if.sv
// Channel control and output bundle between the register block,
// the timer and the capture logic.
interface sample_timer_mc_if #(
    parameter int NUM_CH   = 5,
    parameter int PERIOD_W = 10
);
    logic [NUM_CH-1:0]          en;
    logic [NUM_CH-1:0]          oneshot;
    logic [NUM_CH*PERIOD_W-1:0] scp_period;
    logic [NUM_CH*2-1:0]        scp_unit;
    logic [NUM_CH-1:0]          clk_o;
    logic [NUM_CH-1:0]          strb_o;
    logic [NUM_CH-1:0]          busy_o;
    logic [NUM_CH-1:0]          done_o;

    modport master (
        output en, oneshot, scp_period, scp_unit,
        input  clk_o, strb_o, busy_o, done_o
    );

    modport slave (
        input  en, oneshot, scp_period, scp_unit,
        output clk_o, strb_o, busy_o, done_o
    );
endinterface

// File: rtl/sample_timer_mc_ch.sv
// One timer channel: shadowed period/unit/mode, cycle and unit
// counters, IDLE/RUN/HOLD control and registered outputs.
module sample_timer_ch
    import sample_timer_pkg::*;
#(
    parameter int CLK_FREQ_MHZ = 100,
    parameter int PERIOD_W     = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_i,
    input  logic                oneshot_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic [1:0]          unit_i,
    output logic                clk_o,
    output logic                strb_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int CW = cyc_w(CLK_FREQ_MHZ);

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] per_q, per_d;
    logic [1:0]          unit_q, unit_d;
    logic                os_q, os_d;
    logic [CW-1:0]       cyc_q, cyc_d;
    logic [PERIOD_W-1:0] ucnt_q, ucnt_d;
    logic                clk_q, clk_d;
    logic                strb_q, strb_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [CW-1:0]       u_last;
    logic [PERIOD_W:0]   half;
    logic [PERIOD_W-1:0] ucnt_nx;
    logic                cyc_end;
    logic                per_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            per_q   <= '0;
            unit_q  <= '0;
            os_q    <= 1'b0;
            cyc_q   <= '0;
            ucnt_q  <= '0;
            clk_q   <= 1'b0;
            strb_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            unit_q  <= unit_d;
            os_q    <= os_d;
            cyc_q   <= cyc_d;
            ucnt_q  <= ucnt_d;
            clk_q   <= clk_d;
            strb_q  <= strb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        u_last  = CW'(unit_mult(unit_q) * CLK_FREQ_MHZ - 1);
        half    = ({1'b0, per_q} + {{PERIOD_W{1'b0}}, 1'b1}) >> 1;
        cyc_end = (cyc_q == u_last);
        per_end = cyc_end && (ucnt_q == per_q - 1'b1);
        ucnt_nx = cyc_end ? ucnt_q + 1'b1 : ucnt_q;

        state_d = state_q;
        per_d   = per_q;
        unit_d  = unit_q;
        os_d    = os_q;
        cyc_d   = cyc_q;
        ucnt_d  = ucnt_q;
        clk_d   = 1'b0;
        strb_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                per_d  = period_i;
                unit_d = unit_i;
                os_d   = oneshot_i;
                cyc_d  = '0;
                ucnt_d = '0;
                if (en_i && period_i != '0) begin
                    state_d = RUN;
                    clk_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (!en_i) begin
                    // Truncated period: drop out silently.
                    state_d = IDLE;
                    cyc_d   = '0;
                    ucnt_d  = '0;
                end else if (per_end) begin
                    strb_d = 1'b1;
                    cyc_d  = '0;
                    ucnt_d = '0;
                    per_d  = period_i;
                    unit_d = unit_i;
                    os_d   = oneshot_i;
                    if (os_q) begin
                        done_d  = 1'b1;
                        state_d = HOLD;
                    end else if (period_i == '0) begin
                        state_d = IDLE;
                    end else begin
                        clk_d  = 1'b1;
                        busy_d = 1'b1;
                    end
                end else begin
                    cyc_d  = cyc_end ? '0 : cyc_q + 1'b1;
                    ucnt_d = ucnt_nx;
                    clk_d  = ({1'b0, ucnt_nx} < half);
                    busy_d = 1'b1;
                end
            end
            HOLD: begin
                if (!en_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign clk_o  = clk_q;
    assign strb_o = strb_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: rtl/sample_timer_mc.sv
// Multi-channel sample timer top: slices the control buses
// and instantiates one independent channel per lane.
module sample_timer_mc #(
    parameter int CLK_FREQ_MHZ = 100,
    parameter int NUM_CH       = 5,
    parameter int PERIOD_W     = 10
) (
    input  logic             clk,
    input  logic             rst,
    sample_timer_mc_if.slave bus
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sample_timer_ch #(
            .CLK_FREQ_MHZ(CLK_FREQ_MHZ),
            .PERIOD_W    (PERIOD_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en_i     (bus.en[i]),
            .oneshot_i(bus.oneshot[i]),
            .period_i (bus.scp_period[i*PERIOD_W +: PERIOD_W]),
            .unit_i   (bus.scp_unit[i*2 +: 2]),
            .clk_o    (bus.clk_o[i]),
            .strb_o   (bus.strb_o[i]),
            .busy_o   (bus.busy_o[i]),
            .done_o   (bus.done_o[i])
        );
    end

endmodule
